// File: rtl/pe_mm_ctrl_pkg.sv
// Shared types and timing constants for the pe_mm_ctrl sequencer.
package pe_mm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_FIN
  } state_t;

  localparam int PE_ACC_LATENCY = 3;
  localparam int MEM_RD_LATENCY = 1;
  localparam int DRAIN_TIMEOUT  = 8;

endpackage

// File: rtl/pe_mm_addr_gen.sv
// i/j/k loop counters with running base/stride address registers for A, B and C.
module pe_mm_addr_gen
  import pe_mm_ctrl_pkg::*;
#(
  parameter int DIM_WIDTH  = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  dim_m,
  input  logic [DIM_WIDTH-1:0]  dim_n,
  input  logic [DIM_WIDTH-1:0]  dim_k,
  input  logic                  step_k,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  k_first,
  output logic                  k_last,
  output logic                  j_last,
  output logic                  i_last
);

  logic [DIM_WIDTH-1:0]  m_reg, n_reg, k_reg;
  logic [DIM_WIDTH-1:0]  i_reg, j_reg, kk_reg;
  logic [ADDR_WIDTH-1:0] a_row_reg, a_addr_reg, b_addr_reg, c_addr_reg;
  logic [ADDR_WIDTH-1:0] n_ext, k_ext;

  assign n_ext   = ADDR_WIDTH'(n_reg);
  assign k_ext   = ADDR_WIDTH'(k_reg);
  assign k_first = (kk_reg == '0);
  assign k_last  = (kk_reg == k_reg - 1'b1);
  assign j_last  = (j_reg == n_reg - 1'b1);
  assign i_last  = (i_reg == m_reg - 1'b1);

  assign a_addr = a_addr_reg;
  assign b_addr = b_addr_reg;
  assign c_addr = c_addr_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      m_reg      <= '0;
      n_reg      <= '0;
      k_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      kk_reg     <= '0;
      a_row_reg  <= '0;
      a_addr_reg <= '0;
      b_addr_reg <= '0;
      c_addr_reg <= '0;
    end else if (start) begin
      m_reg      <= dim_m;
      n_reg      <= dim_n;
      k_reg      <= dim_k;
      i_reg      <= '0;
      j_reg      <= '0;
      kk_reg     <= '0;
      a_row_reg  <= '0;
      a_addr_reg <= '0;
      b_addr_reg <= '0;
      c_addr_reg <= '0;
    end else if (step_k) begin
      // A walks along its row, B steps down its column by one row stride
      kk_reg     <= k_last ? '0 : kk_reg + 1'b1;
      a_addr_reg <= a_addr_reg + 1'b1;
      b_addr_reg <= b_addr_reg + n_ext;
    end else if (advance) begin
      kk_reg     <= '0;
      c_addr_reg <= c_addr_reg + 1'b1;
      if (j_last) begin
        j_reg      <= '0;
        i_reg      <= i_reg + 1'b1;
        a_row_reg  <= a_row_reg + k_ext;
        a_addr_reg <= a_row_reg + k_ext;
        b_addr_reg <= '0;
      end else begin
        j_reg      <= j_reg + 1'b1;
        a_addr_reg <= a_row_reg;
        b_addr_reg <= ADDR_WIDTH'(j_reg) + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pe_mm_ctrl.sv
// Matrix-multiply sequencer driving a single MAC PE, one C element at a time.
// Optional PE_MM_CTRL_PERF_EN adds a 32-bit busy-cycle counter output perf_cycles.
module pe_mm_ctrl
  import pe_mm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int DIM_WIDTH  = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DIM_WIDTH-1:0]  cmd_m,
  input  logic [DIM_WIDTH-1:0]  cmd_n,
  input  logic [DIM_WIDTH-1:0]  cmd_k,
  output logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  c_we,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [ACC_WIDTH-1:0]  c_wdata,
  output logic                  pe_clr_n,
  output logic                  pe_start,
  output logic                  pe_valid_in,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [ACC_WIDTH-1:0]  pe_c,
  input  logic                  pe_output_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef PE_MM_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  // Watchdog counter sized with headroom beyond both the timeout and the PE latency
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + PE_ACC_LATENCY + 1);

  state_t              state_reg, state_next;
  logic                err_reg, err_next;
  logic [WD_W-1:0]     wd_cnt_reg;
  logic [ACC_WIDTH-1:0] result_reg;
  logic                ag_start, step_k, advance;
  logic                k_first, k_last, j_last, i_last;
  logic                dims_zero, issuing;
  logic [2:0]          issue_flags;
  logic [2:0]          flag_pipe [MEM_RD_LATENCY];

  pe_mm_addr_gen #(
    .DIM_WIDTH (DIM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .clr    (clr),
    .start  (ag_start),
    .dim_m  (cmd_m),
    .dim_n  (cmd_n),
    .dim_k  (cmd_k),
    .step_k (step_k),
    .advance(advance),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .c_addr (c_addr),
    .k_first(k_first),
    .k_last (k_last),
    .j_last (j_last),
    .i_last (i_last)
  );

  assign dims_zero = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0);
  assign issuing   = (state_reg == ST_ISSUE);

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    ag_start   = 1'b0;
    step_k     = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_next = dims_zero;
          if (dims_zero) begin
            state_next = ST_FIN;
          end else begin
            ag_start   = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        step_k = 1'b1;
        if (k_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pe_output_valid) begin
          state_next = ST_WRITE;
        end else if (wd_cnt_reg == WD_W'(DRAIN_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_FIN;
        end
      end
      ST_WRITE: begin
        advance    = 1'b1;
        state_next = (i_last && j_last) ? ST_FIN : ST_ISSUE;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      err_reg    <= 1'b0;
      wd_cnt_reg <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (issuing) wd_cnt_reg <= '0;
      else if (state_reg == ST_DRAIN) wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (state_reg == ST_DRAIN && pe_output_valid) result_reg <= pe_c;
    end
  end

  // Flags ride alongside the operand read so they meet a_rdata/b_rdata at the PE
  assign issue_flags = {issuing, issuing & k_first, issuing & k_last};

  genvar gi;
  generate
    for (gi = 0; gi < MEM_RD_LATENCY; gi++) begin : g_flag_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (clr) flag_pipe[gi] <= '0;
          else     flag_pipe[gi] <= issue_flags;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (clr) flag_pipe[gi] <= '0;
          else     flag_pipe[gi] <= flag_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign pe_valid_in = flag_pipe[MEM_RD_LATENCY-1][2];
  assign pe_start    = flag_pipe[MEM_RD_LATENCY-1][1];
  assign pe_last     = flag_pipe[MEM_RD_LATENCY-1][0];
  assign pe_a        = a_rdata;
  assign pe_b        = b_rdata;
  assign pe_clr_n    = ~clr;

  assign cmd_ready = (state_reg == ST_IDLE) && !clr;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FIN) && !clr;
  assign c_we      = (state_reg == ST_WRITE) && !clr;
  assign c_wdata   = result_reg;
  assign err       = err_reg;

`ifdef PE_MM_CTRL_PERF_EN
  logic [31:0] perf_reg;
  always_ff @(posedge clk) begin
    if (clr)                                   perf_reg <= '0;
    else if (state_reg == ST_IDLE && cmd_valid) perf_reg <= '0;
    else if (busy)                             perf_reg <= perf_reg + 32'd1;
  end
  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_pe_mm_ctrl.sv
// Directed bench for pe_mm_ctrl with behavioural operand memories and a MAC PE model.
module tb_pe_mm_ctrl;

  localparam int DW = 4;
  localparam int AW = 16;
  localparam int MW = 5;
  localparam int ADW = 8;

  logic clk = 1'b0;
  logic clr;
  logic cmd_valid, cmd_ready;
  logic [MW-1:0] cmd_m, cmd_n, cmd_k;
  logic [ADW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_rdata, b_rdata, pe_a, pe_b;
  logic c_we;
  logic [AW-1:0] c_wdata, pe_c;
  logic pe_clr_n, pe_start, pe_valid_in, pe_last, pe_output_valid;
  logic busy, done, err;
`ifdef PE_MM_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  pe_mm_ctrl #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .DIM_WIDTH(MW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
    .a_addr(a_addr), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .pe_clr_n(pe_clr_n), .pe_start(pe_start), .pe_valid_in(pe_valid_in),
    .pe_last(pe_last), .pe_a(pe_a), .pe_b(pe_b),
    .pe_c(pe_c), .pe_output_valid(pe_output_valid),
    .busy(busy), .done(done), .err(err)
`ifdef PE_MM_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Operand memories with one-cycle registered read
  logic [DW-1:0] amem [256];
  logic [DW-1:0] bmem [256];
  always @(posedge clk) begin
    a_rdata <= amem[a_addr];
    b_rdata <= bmem[b_addr];
  end

  // PE model: accumulate on valid, result valid three cycles after the last beat
  logic [AW-1:0] acc, pe_res, mac;
  logic [2:0] dly;
  logic pe_dead;
  assign mac = (pe_start ? '0 : acc) + AW'(pe_a) * AW'(pe_b);
  always @(posedge clk) begin
    if (!pe_clr_n) begin
      acc <= '0; pe_res <= '0; dly <= '0;
    end else begin
      dly <= {dly[1:0], pe_valid_in && pe_last};
      if (pe_valid_in) acc <= mac;
      if (pe_valid_in && pe_last) pe_res <= mac;
    end
  end
  assign pe_output_valid = dly[2] && !pe_dead;
  assign pe_c = pe_res;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int lat, wr_cnt;
  logic [15:0] wr_addr [16];
  logic [15:0] wr_data [16];
  bit seen_sl, seen_valid, a_moved;
  logic err_done;
  logic [ADW-1:0] a_prev;

  task automatic issue_cmd(input int m, input int n, input int k);
    @(negedge clk);
    a_prev = a_addr;
    cmd_m = MW'(m); cmd_n = MW'(n); cmd_k = MW'(k);
    cmd_valid = 1'b1;
    @(posedge clk);
  endtask

  // Samples one negedge per cycle after acceptance; lat = cycle index of done, -1 if none
  task automatic watch(input int budget);
    lat = -1; wr_cnt = 0; seen_sl = 0; seen_valid = 0; a_moved = 0; err_done = 1'bx;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c_we && wr_cnt < 16) begin
        wr_addr[wr_cnt] = 16'(c_addr);
        wr_data[wr_cnt] = c_wdata;
        wr_cnt++;
      end
      if (pe_valid_in) seen_valid = 1;
      if (pe_start && pe_last) seen_sl = 1;
      if (a_addr != a_prev) a_moved = 1;
      if (done) begin
        lat = c;
        err_done = err;
      end
    end
  endtask

  int exp_c [4];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_m = '0; cmd_n = '0; cmd_k = '0; pe_dead = 1'b0;
    for (int x = 0; x < 256; x++) begin
      amem[x] = '0;
      bmem[x] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready_in_clr", 32'(cmd_ready), 0);
    check("rst_pe_clr_n_in_clr", 32'(pe_clr_n), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cmd_ready_after", 32'(cmd_ready), 1);
    check("rst_pe_clr_n_after", 32'(pe_clr_n), 1);
    check("rst_err", 32'(err), 0);
    check("rst_c_we", 32'(c_we), 0);
    check("rst_a_addr", 32'(a_addr), 0);

    // 1x1x1: 3*5
    amem[0] = 4'd3; bmem[0] = 4'd5;
    issue_cmd(1, 1, 1);
    watch(20);
    $display("[TB] cmd 1x1x1 lat=%0d writes=%0d", lat, wr_cnt);
    check("t1_latency", 32'(lat), 7);
    check("t1_writes", 32'(wr_cnt), 1);
    check("t1_addr", 32'(wr_addr[0]), 0);
    check("t1_data", 32'(wr_data[0]), 15);
    check("t1_start_last", 32'(seen_sl), 1);
    check("t1_err", 32'(err_done), 0);

    // 2x2x16 with patterned operands, reference computed here
    for (int x = 0; x < 32; x++) begin
      amem[x] = DW'((x * 7 + 3) % 16);
      bmem[x] = DW'((x * 5 + 1) % 16);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        exp_c[i*2+j] = 0;
        for (int k = 0; k < 16; k++)
          exp_c[i*2+j] += ((i*16+k) * 7 + 3) % 16 * (((k*2+j) * 5 + 1) % 16);
      end
    issue_cmd(2, 2, 16);
    watch(200);
    $display("[TB] cmd 2x2x16 lat=%0d writes=%0d", lat, wr_cnt);
    check("t2_latency", 32'(lat), 85);
    check("t2_writes", 32'(wr_cnt), 4);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("t2_addr%0d", e), 32'(wr_addr[e]), 32'(e));
      check($sformatf("t2_data%0d", e), 32'(wr_data[e]), 32'(exp_c[e]));
    end
    check("t2_err", 32'(err_done), 0);
`ifdef PE_MM_CTRL_PERF_EN
    @(posedge clk);
    #1;
    check("t2_perf_cycles", perf_cycles, 85);
`endif

    // Zero dimension: immediate done with err, no activity
    issue_cmd(1, 1, 0);
    watch(20);
    $display("[TB] cmd 1x1x0 lat=%0d writes=%0d", lat, wr_cnt);
    check("t3_latency", 32'(lat), 1);
    check("t3_err", 32'(err_done), 1);
    check("t3_valid_seen", 32'(seen_valid), 0);
    check("t3_writes", 32'(wr_cnt), 0);
    check("t3_a_addr_moved", 32'(a_moved), 0);
    @(posedge clk);
    #1;
    check("t3_err_sticky", 32'(err), 1);
    check("t3_idle", 32'(busy), 0);

    // Dead PE: watchdog fires 8 cycles after drain entry (K=2 -> done at 1+2+8)
    pe_dead = 1'b1;
    issue_cmd(1, 1, 2);
    watch(40);
    $display("[TB] cmd 1x1x2 dead-pe lat=%0d writes=%0d", lat, wr_cnt);
    check("t4_latency", 32'(lat), 11);
    check("t4_err", 32'(err_done), 1);
    check("t4_writes", 32'(wr_cnt), 0);
    pe_dead = 1'b0;

    // clr during second element of 2x2x4
    issue_cmd(2, 2, 4);
    watch(11);
    $display("[TB] cmd 2x2x4 pre-clr done_at=%0d writes=%0d", lat, wr_cnt);
    check("t5_no_early_done", 32'(lat), 32'hFFFF_FFFF);
    check("t5_first_write", 32'(wr_cnt), 1);
    check("t5_err_cleared", 32'(err), 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("t5_cmd_ready", 32'(cmd_ready), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_c_we", 32'(c_we), 0);
    check("t5_done", 32'(done), 0);
    check("t5_pe_valid_in", 32'(pe_valid_in), 0);
    check("t5_pe_clr_n", 32'(pe_clr_n), 0);
    @(negedge clk);
    clr = 1'b0;
    watch(30);
    $display("[TB] post-clr idle done_at=%0d writes=%0d", lat, wr_cnt);
    check("t5_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("t5_no_writes", 32'(wr_cnt), 0);
    check("t5_ready_again", 32'(cmd_ready), 1);

    amem[0] = 4'd3; bmem[0] = 4'd5;
    issue_cmd(1, 1, 1);
    watch(20);
    $display("[TB] cmd 1x1x1 after clr lat=%0d writes=%0d", lat, wr_cnt);
    check("t6_latency", 32'(lat), 7);
    check("t6_writes", 32'(wr_cnt), 1);
    check("t6_data", 32'(wr_data[0]), 15);
    check("t6_err", 32'(err_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
